// File: rtl/line_clear_engine.sv
// Settled-playfield engine: merges locked pieces, removes full rows bottom-up
// and compacts the stack, then reports the number of rows removed for one cycle.
module line_clear_engine #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Clear_Board,
  input  logic                 Lock_Valid,
  input  logic [ROWS*COLS-1:0] Lock_Mask,
  output logic                 Lock_Ready,
  output logic [ROWS*COLS-1:0] Board,
  output logic [2:0]           Rows_Cleared,
  output logic                 Overlap,
  output logic                 Top_Out
);

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [RW-1:0]  r_row;
  logic [2:0]     r_count;
  logic [N-1:0]   r_board;
  logic [N-1:0]   w_shifted;
  logic [2:0]     r_rows_cleared;
  logic           r_overlap;
  logic           r_top_out;
  logic [31:0]    w_row_idx;
  logic           w_row_full;
  logic           w_accept;

  assign w_row_idx  = 32'(r_row);
  assign w_row_full = &r_board[w_row_idx*COLS +: COLS];

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else if (Clear_Board) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SCAN;
      SCAN: begin
        if (w_row_full)         w_next_state = SHIFT;
        else if (r_row == '0)   w_next_state = DONE;
      end
      SHIFT:   w_next_state = SCAN;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Lock_Ready = (r_state == IDLE) && !Clear_Board;
    w_accept   = Lock_Ready && Lock_Valid;
  end

  // Collapse: rows 1..r take the row above, row 0 becomes empty
  always_comb begin
    w_shifted           = r_board;
    w_shifted[COLS-1:0] = '0;
    for (int unsigned i = 1; i < ROWS; i++) begin
      if (i <= w_row_idx) begin
        w_shifted[i*COLS +: COLS] = r_board[(i-1)*COLS +: COLS];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_board        <= '0;
      r_row          <= '0;
      r_count        <= '0;
      r_rows_cleared <= '0;
      r_overlap      <= 1'b0;
      r_top_out      <= 1'b0;
    end else if (Clear_Board) begin
      r_board        <= '0;
      r_rows_cleared <= '0;
      r_overlap      <= 1'b0;
      r_top_out      <= 1'b0;
    end else begin
      r_rows_cleared <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_board   <= r_board | Lock_Mask;
            r_overlap <= r_overlap | (|(r_board & Lock_Mask));
            r_row     <= RW'(ROWS - 1);
            r_count   <= '0;
          end
        end
        SCAN: begin
          // The pulse is loaded on entry to DONE so it is visible only there
          if (!w_row_full) begin
            if (r_row == '0) r_rows_cleared <= r_count;
            else             r_row          <= r_row - 1'b1;
          end
        end
        SHIFT: begin
          r_board <= w_shifted;
          r_count <= (r_count == 3'd4) ? 3'd4 : r_count + 3'd1;
        end
        DONE: begin
          r_top_out <= |r_board[COLS-1:0];
        end
        default: ;
      endcase
    end
  end

  assign Board        = r_board;
  assign Rows_Cleared = r_rows_cleared;
  assign Overlap      = r_overlap;
  assign Top_Out      = r_top_out;

endmodule
